// File: rtl/cpu_run_controller.sv
// Run controller for the single-cycle core: counted reset hold, RUN/STEP/HALT
// sequencing, debounced single-step button, PC breakpoint and commit counter.
module cpu_run_controller #(
  parameter int RST_HOLD_CYCLES = 350,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PC_W            = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      mode_sel,
  input  logic            step_btn,
  input  logic            bp_en,
  input  logic [PC_W-1:0] bp_addr,
  input  logic [PC_W-1:0] cpu_pc,
  output logic            cpu_rst,
  output logic            cpu_en,
  output logic            halted,
  output logic [2:0]      state_o,
  output logic [31:0]     cycle_cnt
);

  localparam int HOLD_W = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
  localparam int DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    HOLD      = 3'd0,
    RUN       = 3'd1,
    STEP_WAIT = 3'd2,
    STEP_EXEC = 3'd3,
    HALT      = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [1:0]        sync_q, sync_d;
  logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
  logic              deb_level_q, deb_level_d;
  logic              deb_prev_q, deb_prev_d;
  logic              bp_skip_q, bp_skip_d;
  logic [31:0]       cycle_cnt_q, cycle_cnt_d;

  logic   press;
  logic   bp_hit;
  logic   cpu_en_c;
  state_t mode_target;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= HOLD;
      hold_cnt_q  <= '0;
      sync_q      <= '0;
      deb_cnt_q   <= '0;
      deb_level_q <= 1'b0;
      deb_prev_q  <= 1'b0;
      bp_skip_q   <= 1'b0;
      cycle_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      sync_q      <= sync_d;
      deb_cnt_q   <= deb_cnt_d;
      deb_level_q <= deb_level_d;
      deb_prev_q  <= deb_prev_d;
      bp_skip_q   <= bp_skip_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  // Debounce: the level only flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    sync_d      = {sync_q[0], step_btn};
    deb_cnt_d   = '0;
    deb_level_d = deb_level_q;
    deb_prev_d  = deb_level_q;
    if (sync_q[1] != deb_level_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        deb_level_d = ~deb_level_q;
      end else begin
        deb_cnt_d = deb_cnt_q + DEB_W'(1);
      end
    end
  end

  assign press    = deb_level_q & ~deb_prev_q;
  assign bp_hit   = bp_en && (cpu_pc == bp_addr) && !bp_skip_q;
  assign cpu_en_c = ((state_q == RUN) && !bp_hit) || (state_q == STEP_EXEC);

  always_comb begin
    mode_target = HALT;
    if (mode_sel == 2'b00) begin
      mode_target = RUN;
    end else if (mode_sel == 2'b01) begin
      mode_target = STEP_WAIT;
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    bp_skip_d   = bp_skip_q;
    cycle_cnt_d = cycle_cnt_q;

    if (cpu_en_c) begin
      cycle_cnt_d = cycle_cnt_q + 32'd1;
    end

    unique case (state_q)
      HOLD: begin
        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        if (hold_cnt_q == HOLD_LAST) begin
          state_d = mode_target;
        end
      end
      RUN: begin
        if (cpu_en_c) begin
          bp_skip_d = 1'b0;
        end
        if (bp_hit) begin
          state_d = HALT;
        end else if (mode_sel != 2'b00) begin
          state_d = mode_target;
        end
      end
      STEP_WAIT: begin
        if (mode_sel != 2'b01) begin
          state_d = mode_target;
        end else if (press) begin
          state_d = STEP_EXEC;
        end
      end
      STEP_EXEC: begin
        state_d = mode_sel[1] ? HALT : STEP_WAIT;
      end
      HALT: begin
        // Resuming from a breakpoint must execute that instruction once.
        if (press && mode_sel == 2'b00) begin
          state_d   = RUN;
          bp_skip_d = 1'b1;
        end else if (press && mode_sel == 2'b01) begin
          state_d = STEP_EXEC;
        end
      end
      default: state_d = HOLD;
    endcase
  end

  assign cpu_rst   = (state_q == HOLD);
  assign halted    = (state_q == HALT);
  assign cpu_en    = cpu_en_c;
  assign state_o   = state_q;
  assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed bench for cpu_run_controller: reset hold, mode table, breakpoint
// halt/resume, debounce behaviour and asynchronous reset mid-run.
module tb_cpu_run_controller;

  localparam int HOLD = 8;
  localparam int DEB  = 4;
  localparam int PC_W = 32;

  localparam logic [2:0] S_HOLD = 3'd0;
  localparam logic [2:0] S_RUN  = 3'd1;
  localparam logic [2:0] S_SW   = 3'd2;
  localparam logic [2:0] S_SE   = 3'd3;
  localparam logic [2:0] S_HALT = 3'd4;

  logic            clk;
  logic            rst;
  logic [1:0]      mode_sel;
  logic            step_btn;
  logic            bp_en;
  logic [PC_W-1:0] bp_addr;
  logic [PC_W-1:0] cpu_pc;
  logic            cpu_rst;
  logic            cpu_en;
  logic            halted;
  logic [2:0]      state_o;
  logic [31:0]     cycle_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  cpu_run_controller #(
    .RST_HOLD_CYCLES(HOLD),
    .DEBOUNCE_CYCLES(DEB),
    .PC_W(PC_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mode_sel(mode_sel),
    .step_btn(step_btn),
    .bp_en(bp_en),
    .bp_addr(bp_addr),
    .cpu_pc(cpu_pc),
    .cpu_rst(cpu_rst),
    .cpu_en(cpu_en),
    .halted(halted),
    .state_o(state_o),
    .cycle_cnt(cycle_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Core model: PC starts at 0 in reset and advances by 4 per committed instruction.
  initial begin
    logic en_s;
    logic rs_s;
    cpu_pc = '0;
    forever begin
      @(negedge clk);
      en_s = cpu_en;
      rs_s = cpu_rst;
      @(posedge clk);
      #1;
      if (rs_s) cpu_pc = '0;
      else if (en_s) cpu_pc = cpu_pc + 32'd4;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_hold(input string tag);
    check({tag, "_rst_at_release"}, {31'd0, cpu_rst}, 32'd1);
    for (int k = 1; k <= HOLD; k++) begin
      tick();
      if (k < HOLD) check($sformatf("%s_hold_%0d", tag, k), {31'd0, cpu_rst}, 32'd1);
      else          check($sformatf("%s_hold_end", tag), {31'd0, cpu_rst}, 32'd0);
    end
  endtask

  task automatic do_reset(input logic [1:0] mode, input string tag);
    rst = 1'b1;
    mode_sel = mode;
    tick();
    tick();
    check({tag, "_rst_state"}, {29'd0, state_o}, {29'd0, S_HOLD});
    check({tag, "_rst_cpu_rst"}, {31'd0, cpu_rst}, 32'd1);
    check({tag, "_rst_cpu_en"}, {31'd0, cpu_en}, 32'd0);
    check({tag, "_rst_halted"}, {31'd0, halted}, 32'd0);
    check({tag, "_rst_cnt"}, cycle_cnt, 32'd0);
    rst = 1'b0;
    check_hold(tag);
  endtask

  typedef struct {
    logic [1:0] mode;
    logic [2:0] st;
    logic       en;
    logic       hlt;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int pulses;

    vecs[0] = '{2'b00, S_RUN,  1'b1, 1'b0};
    vecs[1] = '{2'b01, S_SW,   1'b0, 1'b0};
    vecs[2] = '{2'b01, S_SW,   1'b0, 1'b0};
    vecs[3] = '{2'b00, S_RUN,  1'b1, 1'b0};
    vecs[4] = '{2'b01, S_SW,   1'b0, 1'b0};
    vecs[5] = '{2'b11, S_HALT, 1'b0, 1'b1};
    vecs[6] = '{2'b00, S_HALT, 1'b0, 1'b1};
    vecs[7] = '{2'b01, S_HALT, 1'b0, 1'b1};
    vecs[8] = '{2'b10, S_HALT, 1'b0, 1'b1};

    rst      = 1'b1;
    mode_sel = 2'b00;
    step_btn = 1'b0;
    bp_en    = 1'b0;
    bp_addr  = '0;

    // Reset hold, then continuous run.
    do_reset(2'b00, "t1");
    check("t1_state_run", {29'd0, state_o}, {29'd0, S_RUN});
    for (int i = 0; i < 10; i++) begin
      check($sformatf("t1_en_%0d", i), {31'd0, cpu_en}, 32'd1);
      tick();
    end
    check("t1_cnt10", cycle_cnt, 32'd10);

    // Mode transitions without button presses.
    for (int i = 0; i < 9; i++) begin
      mode_sel = vecs[i].mode;
      tick();
      check($sformatf("vec%0d_state", i), {29'd0, state_o}, {29'd0, vecs[i].st});
      check($sformatf("vec%0d_en", i), {31'd0, cpu_en}, {31'd0, vecs[i].en});
      check($sformatf("vec%0d_halted", i), {31'd0, halted}, {31'd0, vecs[i].hlt});
    end

    // Breakpoint halt, resume through it, re-armed breakpoint halts again.
    bp_en   = 1'b1;
    bp_addr = 32'h10;
    do_reset(2'b00, "t2");
    for (int i = 0; i < 20 && !halted; i++) begin
      if (state_o == S_RUN && cpu_pc == 32'h10) check("t2_en_at_bp", {31'd0, cpu_en}, 32'd0);
      tick();
    end
    check("t2_halted", {31'd0, halted}, 32'd1);
    check("t2_cnt4", cycle_cnt, 32'd4);
    check("t2_pc", cpu_pc, 32'h10);
    check("t2_en_halt", {31'd0, cpu_en}, 32'd0);
    step_btn = 1'b1;
    for (int i = 0; i < 20 && state_o != S_RUN; i++) tick();
    check("t2_resume_state", {29'd0, state_o}, {29'd0, S_RUN});
    check("t2_resume_pc", cpu_pc, 32'h10);
    check("t2_resume_en", {31'd0, cpu_en}, 32'd1);
    bp_addr  = 32'h20;
    step_btn = 1'b0;
    for (int i = 0; i < 40 && !halted; i++) tick();
    check("t2_rearm_halted", {31'd0, halted}, 32'd1);
    check("t2_rearm_cnt8", cycle_cnt, 32'd8);
    check("t2_rearm_pc", cpu_pc, 32'h20);

    // Held button in STEP_WAIT: one pulse, DEB+3 edges after first sample.
    bp_en = 1'b0;
    do_reset(2'b01, "t3");
    check("t3_state_sw", {29'd0, state_o}, {29'd0, S_SW});
    step_btn = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      check($sformatf("t3_en_edge%0d", n), {31'd0, cpu_en}, {31'd0, (n == DEB + 3)});
    end
    check("t3_cnt1", cycle_cnt, 32'd1);
    check("t3_state_sw_after", {29'd0, state_o}, {29'd0, S_SW});
    step_btn = 1'b0;
    repeat (10) tick();

    // Bouncing button shorter than the debounce window: no step.
    pulses = 0;
    for (int n = 0; n < 30; n++) begin
      if (n % 2 == 0) step_btn = ~step_btn;
      tick();
      if (cpu_en) pulses++;
    end
    step_btn = 1'b0;
    repeat (6) begin
      tick();
      if (cpu_en) pulses++;
    end
    check("t4_no_pulse", pulses, 32'd0);
    check("t4_cnt_same", cycle_cnt, 32'd1);

    // RUN -> HALT on mode change; mode alone never leaves HALT.
    mode_sel = 2'b00;
    tick();
    check("t5_run", {29'd0, state_o}, {29'd0, S_RUN});
    mode_sel = 2'b10;
    tick();
    check("t5_halt", {29'd0, state_o}, {29'd0, S_HALT});
    mode_sel = 2'b00;
    repeat (5) tick();
    check("t5_stay_halted", {31'd0, halted}, 32'd1);
    check("t5_stay_en", {31'd0, cpu_en}, 32'd0);
    check("t5_cnt2", cycle_cnt, 32'd2);

    // Press in HALT with STEP mode executes exactly one instruction.
    mode_sel = 2'b01;
    step_btn = 1'b1;
    pulses = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (cpu_en) begin
        pulses++;
        check("t5b_exec_state", {29'd0, state_o}, {29'd0, S_SE});
      end
    end
    check("t5b_one_pulse", pulses, 32'd1);
    check("t5b_state_sw", {29'd0, state_o}, {29'd0, S_SW});
    check("t5b_cnt3", cycle_cnt, 32'd3);
    step_btn = 1'b0;
    repeat (8) tick();

    // Asynchronous reset between clock edges during RUN.
    do_reset(2'b00, "t6a");
    repeat (5) tick();
    check("t6_cnt5", cycle_cnt, 32'd5);
    #5 rst = 1'b1;
    #1;
    check("t6_async_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("t6_async_cpu_en", {31'd0, cpu_en}, 32'd0);
    check("t6_async_state", {29'd0, state_o}, {29'd0, S_HOLD});
    check("t6_async_cnt", cycle_cnt, 32'd0);
    #1 rst = 1'b0;
    check_hold("t6b");
    check("t6_run_again", {29'd0, state_o}, {29'd0, S_RUN});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
